histo_seq_ctrl: RTL

HISTO_SEQ_CTRL -- requirements
Module: histo_seq_ctrl

---
 rtl/histo_ctrl_pkg.sv | 25 ++
 rtl/histo_ctrl_bitbuf.sv | 35 +++
 rtl/histo_seq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/histo_ctrl_pkg.sv
// Shared definitions for the histogram sequencing controller.
// Holds the controller state encoding, the default frame/bin/count sizes and a
// small width helper used to size buffer indices.
package histo_ctrl_pkg;

  localparam int unsigned FRAME_BITS_DFLT = 1024;
  localparam int unsigned NUM_BINS_DFLT   = 16;
  localparam int unsigned CNT_W_DFLT      = 10;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StLoad,
    StStream,
    StDrain,
    StRdAddr,
    StRdOut
  } state_e;

  // Index width that stays at least one bit wide for a single-entry buffer.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/histo_ctrl_bitbuf.sv
// Frame bit buffer: captures one frame of bits during load and plays them back
// during streaming.
// Ports:
//   clk      clock
//   wr_en    write strobe (one accepted source bit)
//   wr_idx   write position (acceptance order)
//   wr_data  bit to store
//   rd_idx   playback position
//   rd_data  bit at rd_idx (combinational read)
// Contents are not reset; every entry is rewritten before it is played back.
module histo_ctrl_bitbuf
  import histo_ctrl_pkg::*;
#(
  parameter int unsigned Depth = FRAME_BITS_DFLT,
  parameter int unsigned IdxW  = idx_width(Depth)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [IdxW-1:0] wr_idx,
  input  logic            wr_data,
  input  logic [IdxW-1:0] rd_idx,
  output logic            rd_data
);

  logic [Depth-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/histo_seq_ctrl.sv
// Histogram sequencing controller.
// Loads one frame of bits from an upstream ready/valid stream, replays it to a
// histogram datapath as a contiguous valid burst, waits for the datapath to
// settle, then reads every bin back out over a ready/valid readout port.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start                          frame request (sampled in idle only)
//   src_valid/src_data/src_ready   upstream bit stream
//   hist_init                      one-cycle histogram clear
//   hist_valid/hist_bit            registered bit stream to the datapath
//   hist_addr/hist_data            bin select / bin value (one cycle latency)
//   rd_valid/rd_ready              readout handshake
//   rd_bin/rd_count/rd_last        readout beat contents
//   busy, done                     activity flag, frame-complete pulse
module histo_seq_ctrl
  import histo_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_BITS = FRAME_BITS_DFLT,
  parameter int unsigned NUM_BINS   = NUM_BINS_DFLT,
  parameter int unsigned CNT_W      = CNT_W_DFLT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        src_valid,
  input  logic                        src_data,
  output logic                        src_ready,
  output logic                        hist_init,
  output logic                        hist_valid,
  output logic                        hist_bit,
  output logic [$clog2(NUM_BINS)-1:0] hist_addr,
  input  logic [CNT_W-1:0]            hist_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [$clog2(NUM_BINS)-1:0] rd_bin,
  output logic [CNT_W-1:0]            rd_count,
  output logic                        rd_last,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned IdxW = idx_width(FRAME_BITS);
  localparam int unsigned BcW  = $clog2(FRAME_BITS) + 1;
  localparam int unsigned AddrW = $clog2(NUM_BINS);
  localparam int unsigned NcW  = AddrW + 1;
  localparam logic [BcW-1:0] LastBit = BcW'(FRAME_BITS - 1);
  localparam logic [NcW-1:0] LastBin = NcW'(NUM_BINS - 1);

  state_e           state_q, state_d;
  logic [BcW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NcW-1:0]   bin_cnt_q, bin_cnt_d;
  logic             hist_valid_q, hist_valid_d;
  logic             hist_bit_q, hist_bit_d;
  logic [AddrW-1:0] hist_addr_q, hist_addr_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic [AddrW-1:0] rd_bin_q, rd_bin_d;
  logic             rd_last_q, rd_last_d;
  logic             done_q, done_d;

  logic             wr_en;
  logic [IdxW-1:0]  rd_idx;
  logic             bitbuf_rdata;

  assign wr_en = (state_q == StLoad) && src_valid;

  histo_ctrl_bitbuf #(
    .Depth (FRAME_BITS),
    .IdxW  (IdxW)
  ) u_bitbuf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (bit_cnt_q[IdxW-1:0]),
    .wr_data (src_data),
    .rd_idx  (rd_idx),
    .rd_data (bitbuf_rdata)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    bin_cnt_d    = bin_cnt_q;
    hist_addr_d  = hist_addr_q;
    rd_valid_d   = rd_valid_q;
    rd_count_d   = rd_count_q;
    rd_bin_d     = rd_bin_q;
    rd_last_d    = rd_last_q;
    hist_valid_d = 1'b0;
    hist_bit_d   = 1'b0;
    done_d       = 1'b0;
    rd_idx       = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StInit;
        end
      end

      StInit: begin
        bit_cnt_d = '0;
        bin_cnt_d = '0;
        state_d   = StLoad;
      end

      StLoad: begin
        if (src_valid) begin
          bit_cnt_d = bit_cnt_q + BcW'(1);
          if (bit_cnt_q == LastBit) begin
            // Preload the first stream bit so the registered outputs line up
            // with the first STREAM cycle; a one-bit frame has not been
            // written yet, so take it straight from the source.
            state_d      = StStream;
            bit_cnt_d    = '0;
            hist_valid_d = 1'b1;
            hist_bit_d   = (bit_cnt_q == '0) ? src_data : bitbuf_rdata;
          end
        end
      end

      StStream: begin
        if (bit_cnt_q == LastBit) begin
          state_d   = StDrain;
          bit_cnt_d = '0;
        end else begin
          // Look one bit ahead: the output registers present it next cycle.
          bit_cnt_d    = bit_cnt_q + BcW'(1);
          rd_idx       = IdxW'(bit_cnt_q + BcW'(1));
          hist_valid_d = 1'b1;
          hist_bit_d   = bitbuf_rdata;
        end
      end

      StDrain: begin
        if (bit_cnt_q == BcW'(1)) begin
          state_d     = StRdAddr;
          bit_cnt_d   = '0;
          bin_cnt_d   = '0;
          hist_addr_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BcW'(1);
        end
      end

      StRdAddr: begin
        state_d = StRdOut;
      end

      StRdOut: begin
        if (!rd_valid_q) begin
          // Entry cycle: hist_data now reflects hist_addr from RD_ADDR.
          rd_valid_d = 1'b1;
          rd_count_d = hist_data;
          rd_bin_d   = bin_cnt_q[AddrW-1:0];
          rd_last_d  = (bin_cnt_q == LastBin);
        end else if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (rd_last_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            bin_cnt_d   = bin_cnt_q + NcW'(1);
            hist_addr_d = AddrW'(bin_cnt_q + NcW'(1));
            state_d     = StRdAddr;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      bin_cnt_q    <= '0;
      hist_valid_q <= 1'b0;
      hist_bit_q   <= 1'b0;
      hist_addr_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_count_q   <= '0;
      rd_bin_q     <= '0;
      rd_last_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      bin_cnt_q    <= bin_cnt_d;
      hist_valid_q <= hist_valid_d;
      hist_bit_q   <= hist_bit_d;
      hist_addr_q  <= hist_addr_d;
      rd_valid_q   <= rd_valid_d;
      rd_count_q   <= rd_count_d;
      rd_bin_q     <= rd_bin_d;
      rd_last_q    <= rd_last_d;
      done_q       <= done_d;
    end
  end

  assign src_ready  = (state_q == StLoad);
  assign hist_init  = (state_q == StInit);
  assign busy       = (state_q != StIdle);
  assign hist_valid = hist_valid_q;
  assign hist_bit   = hist_bit_q;
  assign hist_addr  = hist_addr_q;
  assign rd_valid   = rd_valid_q;
  assign rd_count   = rd_count_q;
  assign rd_bin     = rd_bin_q;
  assign rd_last    = rd_last_q;
  assign done       = done_q;

endmodule
